// File: rtl/dp_ctrl_pkg.sv
// Shared types and widths for the time-shared datapath controller.
package dp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DP_DATA_W = 12;
  localparam int DP_RES_W  = 17;
  localparam int DONE_W    = 16;

endpackage

// File: rtl/dp_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after i_ptr wins.
// Zero latency; no backpressure, the caller qualifies o_gnt with its own state.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && i_req[(int'(i_ptr) + i) % N]) begin
        w_found                        = 1'b1;
        o_gnt[(int'(i_ptr) + i) % N]   = 1'b1;
        o_idx                          = IW'((int'(i_ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/dp_share_ctrl.sv
// Shares one multicycle datapath among NUM_REQ requesters: grant, hold operand SETTLE_CYC cycles, capture.
// Grant-to-response SETTLE_CYC cycles; requests stall until the response is taken by rsp_ready.
module dp_share_ctrl
  import dp_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = DP_DATA_W,
  parameter int RES_W      = DP_RES_W,
  parameter int SETTLE_CYC = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]            dp_in,
  input  logic [RES_W-1:0]             dp_out,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [RES_W-1:0]             rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic                         busy,
  output logic [DONE_W-1:0]            done_count
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t              r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_op;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rsp_valid;
  logic [RES_W-1:0]    r_rsp_data;
  logic [ID_W-1:0]     r_rsp_id;
  logic [DONE_W-1:0]   r_done_count;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_idx;
  logic                w_take;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign req_ready  = (r_state == IDLE) ? w_gnt : '0;
  assign w_take     = |(req_valid & req_ready);
  // Operand register feeds the datapath in every state, so dp_in moves only on a grant.
  assign dp_in      = r_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_id     = r_rsp_id;
  assign busy       = (r_state != IDLE);
  assign done_count = r_done_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_id         <= '0;
      r_op         <= '0;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_id     <= '0;
      r_done_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_op     <= req_data[int'(w_idx)*DATA_W +: DATA_W];
            r_id     <= w_idx;
            r_rr_ptr <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            r_cnt    <= CNT_W'(SETTLE_CYC - 1);
            r_state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            r_rsp_data  <= dp_out;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_done_count <= r_done_count + 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_share_ctrl.sv
// Directed bench for dp_share_ctrl with a behavioural datapath: dp_out = dp_in*29 + 1234.
module tb_dp_share_ctrl;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 12;
  localparam int RES_W   = 17;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         dp_in;
  logic [RES_W-1:0]          dp_out;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [RES_W-1:0]          rsp_data;
  logic [1:0]                rsp_id;
  logic                      busy;
  logic [15:0]               done_count;

  int n_vec = 0;
  int n_err = 0;

  dp_share_ctrl #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .RES_W      (RES_W),
    .SETTLE_CYC (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .dp_in      (dp_in),
    .dp_out     (dp_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .done_count (done_count)
  );

  assign dp_out = {5'b0, dp_in} * 17'd29 + 17'd1234;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_rsp(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 12) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_rsp_vld"}, 32'(rsp_valid), 32'd1);
  endtask

  // Fairness expectations: grant order and hand-computed results (x*29+1234).
  int          fair_id  [6] = '{0, 1, 2, 3, 0, 1};
  logic [16:0] fair_res [6] = '{17'd1727, 17'd2220, 17'd2713, 17'd3206, 17'd1727, 17'd2220};

  initial begin
    int nrsp;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;

    #1;
    chk("rst_req_ready", 32'(req_ready),  32'd0);
    chk("rst_dp_in",     32'(dp_in),      32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid),  32'd0);
    chk("rst_rsp_data",  32'(rsp_data),   32'd0);
    chk("rst_rsp_id",    32'(rsp_id),     32'd0);
    chk("rst_busy",      32'(busy),       32'd0);
    chk("rst_done",      32'(done_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single request from requester 2, rsp_ready held high throughout.
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_data[2*DATA_W +: DATA_W] = 12'h0A5;
    #1 chk("single_gnt", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = '0;
    chk("single_busy",  32'(busy),      32'd1);
    chk("single_ready0",32'(req_ready), 32'd0);
    chk("single_dp_in", 32'(dp_in),     32'h0A5);
    chk("single_vld_e1",32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("single_vld_e2",32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("single_vld_e3",32'(rsp_valid), 32'd1);
    chk("single_id",    32'(rsp_id),    32'd2);
    chk("single_data",  32'(rsp_data),  32'd6019);
    @(negedge clk);
    chk("single_vld_off",32'(rsp_valid), 32'd0);
    chk("single_idle",   32'(busy),      32'd0);
    chk("single_done",   32'(done_count),32'd1);

    // Reset during SETTLE: requester 1 is granted (pointer sits at 3), then reset hits.
    req_valid = 4'b0010;
    req_data[1*DATA_W +: DATA_W] = 12'h055;
    #1 chk("mid_gnt", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    chk("mid_busy",  32'(busy),  32'd1);
    chk("mid_dp_in", 32'(dp_in), 32'h055);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(busy),       32'd0);
    chk("mid_rst_dp_in", 32'(dp_in),      32'd0);
    chk("mid_rst_vld",   32'(rsp_valid),  32'd0);
    chk("mid_rst_data",  32'(rsp_data),   32'd0);
    chk("mid_rst_id",    32'(rsp_id),     32'd0);
    chk("mid_rst_ready", 32'(req_ready),  32'd0);
    chk("mid_rst_done",  32'(done_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nrsp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    chk("mid_no_rsp", 32'(nrsp), 32'd0);

    // Fairness: all four requesters hold valid continuously.
    req_data  = {12'h044, 12'h033, 12'h022, 12'h011};
    req_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("fair_gnt%0d", i), 32'(req_ready), 32'(4'b0001 << fair_id[i]));
      @(posedge clk);
      wait_rsp($sformatf("fair%0d", i));
      chk($sformatf("fair_id%0d", i),   32'(rsp_id),   32'(fair_id[i]));
      chk($sformatf("fair_data%0d", i), 32'(rsp_data), 32'(fair_res[i]));
      @(negedge clk);
      chk($sformatf("fair_idle%0d", i), 32'(busy), 32'd0);
    end
    req_valid = '0;
    chk("fair_done", 32'(done_count), 32'd6);

    // Settle hold: operand changes after the grant must not reach the datapath.
    req_valid = 4'b0010;
    req_data[1*DATA_W +: DATA_W] = 12'h123;
    #1 chk("hold_gnt", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_data[1*DATA_W +: DATA_W] = 12'hFFF;
    req_valid = '0;
    chk("hold_dp_in1", 32'(dp_in), 32'h123);
    @(negedge clk);
    chk("hold_dp_in2", 32'(dp_in), 32'h123);
    wait_rsp("hold");
    chk("hold_data", 32'(rsp_data), 32'd9673);
    chk("hold_id",   32'(rsp_id),   32'd1);
    @(negedge clk);
    chk("hold_dp_in_idle", 32'(dp_in), 32'h123);

    // Backpressure, with a full-width result (bit 16 set).
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    req_data[3*DATA_W +: DATA_W] = 12'hFFF;
    #1 chk("bp_gnt", 32'(req_ready), 32'b1000);
    @(posedge clk);
    wait_rsp("bp");
    req_valid = 4'hF;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_data%0d", i),  32'(rsp_data),  32'd119989);
      chk($sformatf("bp_id%0d", i),    32'(rsp_id),    32'd3);
      chk($sformatf("bp_vld%0d", i),   32'(rsp_valid), 32'd1);
      chk($sformatf("bp_ready%0d", i), 32'(req_ready), 32'd0);
      chk($sformatf("bp_busy%0d", i),  32'(busy),      32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = '0;
    chk("bp_vld_off", 32'(rsp_valid),  32'd0);
    chk("bp_idle",    32'(busy),       32'd0);
    chk("bp_done",    32'(done_count), 32'd8);
    @(negedge clk);
    chk("bp_done_once", 32'(done_count), 32'd8);

    // done_count wrap.
    force dut.r_done_count = 16'hFFFF;
    #1 release dut.r_done_count;
    chk("wrap_pre", 32'(done_count), 32'hFFFF);
    @(negedge clk);
    req_valid = 4'b0001;
    req_data[0 +: DATA_W] = 12'h011;
    @(negedge clk);
    req_valid = '0;
    wait_rsp("wrap");
    chk("wrap_data", 32'(rsp_data), 32'd1727);
    @(negedge clk);
    chk("wrap_done", 32'(done_count), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dp_share_ctrl.md
# dp_share_ctrl

Time-shares one deep combinational arithmetic datapath (12-bit operand in, 17-bit result out) between `NUM_REQ` requesters. It arbitrates round-robin and holds the winning operand stable on the datapath input for a programmable settle window. It then captures the result and returns it with the requester ID on a valid/ready response channel. It sits between the request-side clients and the shared datapath instance, which is instantiated beside it at the same level.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters; must be ≥2.
- `DATA_W`, 12: operand width.
- `RES_W`, 17: result width.
- `SETTLE_CYC`, 2: cycles the operand is held before capture; must be ≥1; matches the multicycle constraint on the datapath.

Ports:
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, NUM_REQ: per-requester request valid.
- `req_data`, input, NUM_REQ×DATA_W: per-requester operand.
- `req_ready`, output, NUM_REQ: one-hot grant/accept; a handshake occurs where valid and ready are both high at a rising edge.
- `dp_in`, output, DATA_W: operand driven to the shared datapath.
- `dp_out`, input, RES_W: result from the shared datapath.
- `rsp_valid`, output, 1: response valid.
- `rsp_ready`, input, 1: response consumer ready.
- `rsp_data`, output, RES_W: captured result.
- `rsp_id`, output, $clog2(NUM_REQ): index of the requester that owns `rsp_data`.
- `busy`, output, 1: high in any state other than IDLE.
- `done_count`, output, 16: count of completed response handshakes; wraps modulo 2^16.

## Operation

- The FSM has three states: IDLE, SETTLE, RESP.
- IDLE:
  - The round-robin arbiter selects the first asserted `req_valid` at or after pointer `rr_ptr`.
  - `req_ready` is one-hot on that winner, combinationally, and only in IDLE.
  - With no `req_valid` asserted, `req_ready` is 0 and the FSM stays in IDLE.
  - On the handshake: `op_q` ← winner's `req_data`, `id_q` ← winner index, `rr_ptr` ← (winner+1) mod NUM_REQ, `cnt` ← SETTLE_CYC−1, go to SETTLE.
- SETTLE:
  - `dp_in` = `op_q`; `dp_in` is driven from `op_q` in every state, so it changes only on a grant.
  - If `cnt`==0: `rsp_data` ← `dp_out`, `rsp_id` ← `id_q`, `rsp_valid` ← 1, go to RESP.
  - Otherwise `cnt` decrements.
- RESP:
  - `rsp_valid`, `rsp_data` and `rsp_id` are held stable until `rsp_ready`.
  - On the handshake: `rsp_valid` ← 0, `done_count` increments, go to IDLE.
- Requests are never accepted outside IDLE; `req_ready` is 0 in SETTLE and RESP.
- A requester that drops `req_valid` before being granted loses nothing; no state is kept per requester.
- Arithmetic and width rules:
  - `dp_out` is captured verbatim at RES_W bits, with no truncation or extension.
  - `rr_ptr` wraps NUM_REQ−1 → 0.
  - `done_count` wraps 0xFFFF → 0x0000.
- Reset, asserted at any time including mid-operation:
  - Immediately returns to IDLE.
  - Clears `rr_ptr`, `op_q`, `id_q` and `cnt`.
  - The in-flight result is discarded with no response.

## Timing

- Reset values: `req_ready`=0, `dp_in`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0, `done_count`=0.
- Request handshake at edge E0. `rsp_valid` first samples high at edge E0+SETTLE_CYC+1 and is visible from E0+SETTLE_CYC.
- `dp_in` is stable from E0 through the capture edge. The path from `dp_in` to `dp_out` is given SETTLE_CYC cycles.
- If `rsp_ready` is held high, the response handshake completes on the first RESP edge.
- Minimum initiation interval is SETTLE_CYC+2 cycles (IDLE + SETTLE×SETTLE_CYC + RESP). With the default SETTLE_CYC=2 this is 4 cycles.
- `rsp_ready` may be high before `rsp_valid`; no handshake occurs without `rsp_valid`.
- `req_ready` depends combinationally on `req_valid` and state only, never on `rsp_ready`.

## Structure

- Package `dp_ctrl_pkg` holds:
  - the `state_t` enum (IDLE, SETTLE, RESP);
  - localparams `DP_DATA_W`=12 and `DP_RES_W`=17;
  - the `done_count` width of 16.
- Sub-module `rr_arbiter` (parameter N) takes the request vector and pointer and produces a one-hot grant and the encoded index. It is purely combinational and is reused by other shared-resource controllers.
- The FSM, settle counter, capture registers and `done_count` live in `dp_share_ctrl`.
- The shared datapath is external, wired through `dp_in`/`dp_out`.

## Test plan

- Single request: requester 2 presents 0x0A5 with `rsp_ready`=1 and SETTLE_CYC=2.
  - `req_ready`=4'b0100 for one cycle.
  - `rsp_valid` rises 2 cycles after the handshake with `rsp_id`=2 and `rsp_data` equal to the datapath model of 0x0A5.
  - `done_count`=1.
- Fairness: all four requesters hold `req_valid` continuously.
  - Grant order is 0,1,2,3,0,1.
  - Each response's `rsp_id` matches its grant order.
- Backpressure: `rsp_ready`=0 for 10 cycles after `rsp_valid` rises.
  - `rsp_data` and `rsp_id` stay stable, `req_ready` stays 0 and `busy` stays 1.
  - When `rsp_ready`=1, exactly one handshake occurs, then the FSM returns to IDLE.
- Settle hold: change requester data during SETTLE.
  - `dp_in` stays at the granted operand.
  - The captured result matches the granted operand, not the new data.
- Reset mid-operation: assert `rst_n`=0 during SETTLE.
  - All outputs read their reset values asynchronously, and no response is ever produced for that operation.
  - After release, requester 0 is granted first.
- Wrap: preload 65535 responses (or force `done_count` to 0xFFFF) and complete one more response; `done_count` reads 0x0000.
